// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable clock divider
package clk_div_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int DIV_MIN = 2;
  function automatic int unsigned half_cnt(input int unsigned n);
    return n >> 1;
  endfunction
endpackage

// File: rtl/clk_div_nedge.sv
// clk_div_nedge: falling-edge retime flop for the odd-divisor half-cycle extension
module clk_div_nedge (
  input  logic iclk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(negedge iclk) q <= rst ? 1'b0 : d;
endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable 50% duty clock divider with boundary-aligned updates
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DIV_RST = 3
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             oclk,
  output logic             tick,
  output logic             active,
  output logic [DIV_W-1:0] div_cur,
  output logic             div_err
);
  logic [DIV_W-1:0] cnt, cnt_n, shadow, shadow_n, div_cur_n;
  logic pend, p_r, n_r, odd_r, boundary, free, bad_ld, load_ok, apply, active_n, p_n;
  always_comb begin
    boundary  = active && cnt == div_cur - 1'b1;
    free      = boundary || !active;
    bad_ld    = div_load && div_val < DIV_W'(DIV_MIN);
    load_ok   = div_load && !bad_ld;
    shadow_n  = load_ok ? div_val : shadow;
    apply     = (load_ok || pend) && free;
    div_cur_n = apply ? shadow_n : div_cur;
    active_n  = free ? en : 1'b1;
    cnt_n     = (active && !boundary) ? cnt + 1'b1 : '0;
    p_n       = active_n && cnt_n < DIV_W'(half_cnt(32'(div_cur_n)));
  end
  always_ff @(posedge iclk) begin
    if (rst) begin
      cnt     <= '0;
      p_r     <= 1'b0;
      active  <= 1'b0;
      div_cur <= DIV_W'(DIV_RST);
      shadow  <= DIV_W'(DIV_RST);
      pend    <= 1'b0;
      div_err <= 1'b0;
      odd_r   <= DIV_RST[0];
    end else begin
      cnt     <= cnt_n;
      p_r     <= p_n;
      active  <= active_n;
      div_cur <= div_cur_n;
      shadow  <= shadow_n;
      pend    <= (pend || load_ok) && !apply;
      div_err <= div_err || bad_ld;
      odd_r   <= div_cur_n[0];
    end
  end
  clk_div_nedge u_nedge (.iclk(iclk), .rst(rst), .d(p_r), .q(n_r));
  assign oclk = odd_r ? (p_r | n_r) : p_r;
  assign tick = active && cnt == '0;
endmodule
